// File: rtl/rs_correct_pkg.sv
// Shared configuration, derived widths and FSM encoding for the RS correction stage.
package rs_correct_pkg;

  localparam int NUM_WORDS = 50;
  localparam int WORD_W    = 32;

  localparam int IDX_W    = $clog2(NUM_WORDS);
  localparam int BITCNT_W = $clog2(NUM_WORDS * WORD_W + 1);
  localparam int WCNT_W   = $clog2(NUM_WORDS + 1);
  localparam int PC_W     = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/rs_correct_if.sv
// Codeword-in / corrected-word-out bus plus status, between decoder, corrector and consumer.
interface rs_correct_if;
  import rs_correct_pkg::*;

  logic                          in_valid_i;
  logic                          in_ready_o;
  logic [NUM_WORDS*WORD_W-1:0]   codeword_i;
  logic [NUM_WORDS*WORD_W-1:0]   err_pat_i;
  logic                          with_error_i;
  logic                          out_valid_o;
  logic                          out_ready_i;
  logic [WORD_W-1:0]             out_data_o;
  logic [IDX_W-1:0]              out_idx_o;
  logic                          out_last_o;
  logic                          busy_o;
  logic                          done_o;
  logic [BITCNT_W-1:0]           err_bits_o;
  logic [WCNT_W-1:0]             err_words_o;

  modport slave (
    input  in_valid_i, codeword_i, err_pat_i, with_error_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_idx_o, out_last_o,
           busy_o, done_o, err_bits_o, err_words_o
  );

  modport master (
    output in_valid_i, codeword_i, err_pat_i, with_error_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_idx_o, out_last_o,
           busy_o, done_o, err_bits_o, err_words_o
  );

endinterface

// File: rtl/rs_popcount.sv
// Combinational population count of one word.
module rs_popcount
  import rs_correct_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  output logic [PC_W-1:0]   ones_o
);

  always_comb begin
    ones_o = '0;
    for (int i = 0; i < WORD_W; i++) begin
      ones_o = ones_o + PC_W'(word_i[i]);
    end
  end

endmodule

// File: rtl/rs_correct.sv
// Latches a codeword with its error pattern applied and streams it out one word per cycle (word 0 one cycle after accept).
// Output words hold while out_ready_i is low; a new codeword is only taken in IDLE, 52 cycles minimum between accepts.
module rs_correct
  import rs_correct_pkg::*;
(
  input logic         clk_i,
  input logic         rst_i,
  input logic         clear_i,
  rs_correct_if.slave bus
);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BITCNT_W-1:0]   err_bits_q, err_bits_d;
  logic [WCNT_W-1:0]     err_words_q, err_words_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [WORD_W-1:0]     data_buf_q [NUM_WORDS];
  logic [WORD_W-1:0]     data_buf_d [NUM_WORDS];
  logic [WORD_W-1:0]     pat_buf_q  [NUM_WORDS];
  logic [WORD_W-1:0]     pat_buf_d  [NUM_WORDS];

  logic [WORD_W-1:0]     cur_pat;
  logic [PC_W-1:0]       cur_ones;
  logic                  accept;
  logic                  last_idx;

  assign accept   = (state_q == IDLE) && bus.in_valid_i;
  assign last_idx = (idx_q == IDX_W'(NUM_WORDS - 1));
  assign cur_pat  = pat_buf_q[idx_q];

  rs_popcount u_popcount (
    .word_i (cur_pat),
    .ones_o (cur_ones)
  );

  // The applied pattern (zeroed when the decoder saw no error) is kept so the
  // statistics only ever count bits that were actually flipped.
  always_comb begin
    data_buf_d = data_buf_q;
    pat_buf_d  = pat_buf_q;
    if (accept) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        pat_buf_d[k]  = bus.with_error_i ? bus.err_pat_i[k*WORD_W +: WORD_W] : '0;
        data_buf_d[k] = bus.codeword_i[k*WORD_W +: WORD_W] ^ pat_buf_d[k];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    err_bits_d  = err_bits_q;
    err_words_d = err_words_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = done_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid_i) begin
          state_d     = STREAM;
          idx_d       = '0;
          err_bits_d  = '0;
          err_words_d = '0;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
      STREAM: begin
        if (bus.out_ready_i) begin
          err_bits_d  = err_bits_q + BITCNT_W'(cur_ones);
          err_words_d = err_words_q + WCNT_W'(cur_pat != '0);
          if (last_idx) begin
            state_d     = DONE;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        state_d    = IDLE;
        done_d     = 1'b0;
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      err_bits_q  <= '0;
      err_words_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      err_bits_q  <= err_bits_d;
      err_words_q <= err_words_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Buffer contents are meaningless outside STREAM, so they carry no reset.
  always_ff @(posedge clk_i) begin
    data_buf_q <= data_buf_d;
    pat_buf_q  <= pat_buf_d;
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = out_valid_q ? data_buf_q[idx_q] : '0;
  assign bus.out_idx_o   = idx_q;
  assign bus.out_last_o  = out_valid_q && last_idx;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.err_bits_o  = err_bits_q;
  assign bus.err_words_o = err_words_q;

endmodule

// File: tb/tb_rs_correct.sv
// Scoreboard bench for rs_correct: directed codewords, monitor compares every streamed word.
module tb_rs_correct;
  import rs_correct_pkg::*;

  logic clk_i   = 1'b0;
  logic rst_i   = 1'b1;
  logic clear_i = 1'b0;

  rs_correct_if bus ();

  rs_correct dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [WORD_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic              last;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;
  bit   rdy_rand = 1'b0;
  bit   done_exp = 1'b0;
  bit   stall_prev = 1'b0;
  logic [WORD_W-1:0] stall_data;
  logic [IDX_W-1:0]  stall_idx;
  logic [NUM_WORDS*WORD_W-1:0] cw, pat;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Downstream ready: always 1, or a random 1/0 pattern when rdy_rand is set.
  initial begin
    bus.out_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      bus.out_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every handshake, checks stalls and done_o.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i) begin
      stall_prev = 1'b0;
      done_exp   = 1'b0;
    end else begin
      if (done_exp) begin
        chk("done_pulse", bus.done_o, 1);
        done_exp = 1'b0;
      end else if (bus.done_o) begin
        chk("spurious_done", bus.done_o, 0);
      end
      if (stall_prev) begin
        chk("stall_valid", bus.out_valid_o, 1);
        chk("stall_data", bus.out_data_o, stall_data);
        chk("stall_idx", bus.out_idx_o, stall_idx);
      end
      stall_prev = bus.out_valid_o && !bus.out_ready_i && !clear_i;
      stall_data = bus.out_data_o;
      stall_idx  = bus.out_idx_o;
      if (bus.out_valid_o && bus.out_ready_i && !clear_i) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", bus.out_valid_o, 0);
        end else begin
          e = sb.pop_front();
          chk("word_data", bus.out_data_o, e.data);
          chk("word_idx", bus.out_idx_o, e.idx);
          chk("word_last", bus.out_last_o, e.last);
          if (e.last) done_exp = 1'b1;
        end
      end
    end
  end

  // mode 0: zero pattern, 1: three-word table, 2: all ones.
  task automatic load(input logic [WORD_W-1:0] base, input int mode);
    for (int k = 0; k < NUM_WORDS; k++) begin
      cw[k*WORD_W +: WORD_W]  = base + WORD_W'(k);
      pat[k*WORD_W +: WORD_W] = '0;
    end
    if (mode == 1) begin
      pat[3*WORD_W  +: WORD_W] = 32'h0000_0001;
      pat[17*WORD_W +: WORD_W] = 32'hFF00_0000;
      pat[49*WORD_W +: WORD_W] = 32'h8000_0001;
    end else if (mode == 2) begin
      pat = '1;
    end
  endtask

  task automatic push_exp(input bit werr);
    exp_t e;
    for (int k = 0; k < NUM_WORDS; k++) begin
      e.data = cw[k*WORD_W +: WORD_W] ^ (werr ? pat[k*WORD_W +: WORD_W] : '0);
      e.idx  = IDX_W'(k);
      e.last = (k == NUM_WORDS - 1);
      sb.push_back(e);
    end
  endtask

  // Called just after a rising edge; returns the number of edges waited.
  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.in_ready_o && n < 400) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    if (!bus.in_ready_o) chk("in_ready_timeout", bus.in_ready_o, 1);
  endtask

  task automatic issue(input bit werr);
    int n;
    wait_ready(n);
    bus.codeword_i   = cw;
    bus.err_pat_i    = pat;
    bus.with_error_i = werr;
    bus.in_valid_i   = 1'b1;
    push_exp(werr);
    @(posedge clk_i);
    #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic send(input bit werr, output int lat);
    issue(werr);
    wait_ready(lat);
  endtask

  initial begin
    int lat, n, t_acc, t_prev;
    bus.in_valid_i   = 1'b0;
    bus.with_error_i = 1'b0;
    bus.codeword_i   = '0;
    bus.err_pat_i    = '0;
    t_prev = 0;

    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("rst_in_ready", bus.in_ready_o, 1);
    chk("rst_out_valid", bus.out_valid_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_err_bits", bus.err_bits_o, 0);
    chk("rst_err_words", bus.err_words_o, 0);
    chk("rst_idx", bus.out_idx_o, 0);
    chk("rst_last", bus.out_last_o, 0);
    chk("rst_data", bus.out_data_o, 0);

    // 1: clean codeword, full throughput
    load(32'h1000_0000, 0);
    send(1'b0, lat);
    chk("t1_latency", lat, 51);
    chk("t1_err_bits", bus.err_bits_o, 0);
    chk("t1_err_words", bus.err_words_o, 0);

    // 2: three corrupted words
    load(32'h1000_0000, 1);
    send(1'b1, lat);
    chk("t2_latency", lat, 51);
    chk("t2_err_bits", bus.err_bits_o, 11);
    chk("t2_err_words", bus.err_words_o, 3);

    // 3: same with random backpressure
    rdy_rand = 1'b1;
    send(1'b1, lat);
    rdy_rand = 1'b0;
    chk("t3_err_bits", bus.err_bits_o, 11);
    chk("t3_err_words", bus.err_words_o, 3);

    // 4: pattern present but flag low
    load(32'hA5A5_0000, 1);
    send(1'b0, lat);
    chk("t4_err_bits", bus.err_bits_o, 0);
    chk("t4_err_words", bus.err_words_o, 0);

    // 5: clear at idx 20, then a fresh codeword
    load(32'h1000_0000, 1);
    issue(1'b1);
    n = 0;
    while (bus.out_idx_o != IDX_W'(20) && n < 100) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    chk("t5_reach_idx20", bus.out_idx_o, 20);
    chk("t5_partial_bits", bus.err_bits_o, 9);
    chk("t5_partial_words", bus.err_words_o, 2);
    clear_i = 1'b1;
    @(posedge clk_i);
    #1;
    clear_i = 1'b0;
    sb.delete();
    chk("t5_out_valid", bus.out_valid_o, 0);
    chk("t5_in_ready", bus.in_ready_o, 1);
    chk("t5_busy", bus.busy_o, 0);
    chk("t5_err_bits", bus.err_bits_o, 0);
    chk("t5_err_words", bus.err_words_o, 0);
    chk("t5_idx", bus.out_idx_o, 0);
    repeat (3) @(posedge clk_i);
    #1;
    load(32'h2000_0000, 1);
    send(1'b1, lat);
    chk("t5_fresh_latency", lat, 51);
    chk("t5_fresh_err_bits", bus.err_bits_o, 11);
    chk("t5_fresh_err_words", bus.err_words_o, 3);

    // 6: in_valid held high, all-ones pattern
    load(32'h3000_0000, 2);
    bus.codeword_i   = cw;
    bus.err_pat_i    = pat;
    bus.with_error_i = 1'b1;
    bus.in_valid_i   = 1'b1;
    for (int r = 0; r < 2; r++) begin
      wait_ready(n);
      if (r > 0) begin
        chk("t6_err_bits", bus.err_bits_o, 1600);
        chk("t6_err_words", bus.err_words_o, 50);
      end
      push_exp(1'b1);
      @(posedge clk_i);
      #1;
      t_acc = cyc;
      if (r > 0) chk("t6_spacing", t_acc - t_prev, 52);
      t_prev = t_acc;
    end
    wait_ready(n);
    chk("t6_final_err_bits", bus.err_bits_o, 1600);
    chk("t6_final_err_words", bus.err_words_o, 50);
    clear_i = 1'b1;
    @(posedge clk_i);
    #1;
    clear_i        = 1'b0;
    bus.in_valid_i = 1'b0;
    chk("t6_clr_in_ready", bus.in_ready_o, 1);
    chk("t6_clr_busy", bus.busy_o, 0);
    chk("t6_clr_out_valid", bus.out_valid_o, 0);
    chk("t6_clr_err_bits", bus.err_bits_o, 0);
    repeat (3) @(posedge clk_i);
    #1;
    chk("t6_clr_still_idle", bus.busy_o, 0);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors, %0d miscompares", n_vec, n_miss);
    $fatal(1, "watchdog expired");
  end

endmodule
